// File: rtl/sm_ctrl_if.sv
// Host register bus for sm_ctrl: write/read strobes, address, data and registered read return.
interface sm_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output wr_en, rd_en, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/sm_ctrl.sv
// State-machine controller: per-SM enables, fractional-free clock dividers, restart strobes
// and wrap registers behind a small host register map.
module sm_ctrl #(
  parameter int unsigned NUM_SM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sm_ctrl_if.slave              bus,
  output logic [NUM_SM-1:0]     sm_tick,
  output logic [NUM_SM-1:0]     sm_restart,
  output logic [5*NUM_SM-1:0]   wrap_top,
  output logic [5*NUM_SM-1:0]   wrap_bottom
);

  localparam logic [3:0] AddrCtrl = 4'h0;

  logic [NUM_SM-1:0] en_q, en_d;
  logic [NUM_SM-1:0] restart_q, restart_d;
  logic [15:0]       int_q [NUM_SM];
  logic [15:0]       int_d [NUM_SM];
  logic [15:0]       cnt_q [NUM_SM];
  logic [15:0]       cnt_d [NUM_SM];
  logic [4:0]        wbot_q [NUM_SM];
  logic [4:0]        wbot_d [NUM_SM];
  logic [4:0]        wtop_q [NUM_SM];
  logic [4:0]        wtop_d [NUM_SM];
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic              ctrl_wr;
  logic [NUM_SM-1:0] cnt_clr;
  logic [NUM_SM-1:0] at_last;
  logic [16:0]       div   [NUM_SM];
  logic [16:0]       last  [NUM_SM];

  // Register writes and divider counters.
  always_comb begin
    ctrl_wr   = bus.wr_en && (bus.addr == AddrCtrl);
    en_d      = en_q;
    restart_d = '0;
    cnt_clr   = '0;
    sm_tick   = '0;
    at_last   = '0;
    if (ctrl_wr) begin
      en_d      = bus.wdata[NUM_SM-1:0];
      restart_d = bus.wdata[4 +: NUM_SM];
      cnt_clr   = bus.wdata[8 +: NUM_SM];
    end
    for (int i = 0; i < NUM_SM; i++) begin
      int_d[i]  = int_q[i];
      wbot_d[i] = wbot_q[i];
      wtop_d[i] = wtop_q[i];
      if (bus.wr_en && (bus.addr == 4'(1 + i))) begin
        int_d[i]   = bus.wdata[31:16];
        cnt_clr[i] = 1'b1;
      end
      if (bus.wr_en && (bus.addr == 4'(5 + i))) begin
        wbot_d[i] = bus.wdata[4:0];
        wtop_d[i] = bus.wdata[12:8];
      end
      // INT of zero selects the full 65536 divide; 17 bits keep D-1 exact.
      div[i]     = (int_q[i] == 16'd0) ? 17'h10000 : {1'b0, int_q[i]};
      last[i]    = div[i] - 17'd1;
      at_last[i] = ({1'b0, cnt_q[i]} == last[i]);
      sm_tick[i] = en_q[i] & at_last[i];
      cnt_d[i]   = cnt_q[i];
      if (cnt_clr[i]) begin
        cnt_d[i] = '0;
      end else if (en_q[i]) begin
        cnt_d[i] = at_last[i] ? 16'd0 : cnt_q[i] + 16'd1;
      end
    end
  end

  // Read return uses pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rvalid_d = bus.rd_en;
    rdata_d  = rdata_q;
    if (bus.rd_en) begin
      rdata_d = '0;
      if (bus.addr == AddrCtrl) begin
        rdata_d[NUM_SM-1:0] = en_q;
      end
      for (int i = 0; i < NUM_SM; i++) begin
        if (bus.addr == 4'(1 + i)) begin
          rdata_d[31:16] = int_q[i];
        end
        if (bus.addr == 4'(5 + i)) begin
          rdata_d[4:0]  = wbot_q[i];
          rdata_d[12:8] = wtop_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= '0;
      restart_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      for (int i = 0; i < NUM_SM; i++) begin
        int_q[i]  <= 16'd1;
        cnt_q[i]  <= '0;
        wbot_q[i] <= 5'd31;
        wtop_q[i] <= 5'd0;
      end
    end else begin
      en_q      <= en_d;
      restart_q <= restart_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      for (int i = 0; i < NUM_SM; i++) begin
        int_q[i]  <= int_d[i];
        cnt_q[i]  <= cnt_d[i];
        wbot_q[i] <= wbot_d[i];
        wtop_q[i] <= wtop_d[i];
      end
    end
  end

  always_comb begin
    wrap_top    = '0;
    wrap_bottom = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      wrap_top[5*i +: 5]    = wtop_q[i];
      wrap_bottom[5*i +: 5] = wbot_q[i];
    end
  end

  assign sm_restart = restart_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule
